// File: rtl/alu_result_display_pkg.sv
// Shared definitions for the ALU result display: FSM states, product width
// and the active-low 7-segment patterns {g,f,e,d,c,b,a}.
package alu_result_display_pkg;

    localparam int unsigned P_W   = 12;
    localparam int unsigned BCD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Codes 10..15 never come out of the converter; they decode to all-off.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu_result_display_bin2bcd_serial.sv
// Serial double-dabble converter: 12-bit binary to 4 BCD digits, one bit per
// clock, with registered busy/done and a committed result register.
module alu_result_display_bin2bcd_serial
    import alu_result_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [P_W-1:0]   din,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    state_t             state;
    logic [P_W-1:0]     shreg;
    logic [3:0]         cnt;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;

    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            scratch <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= din;
                        cnt     <= 4'(P_W);
                        scratch <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[BCD_W-2:0], shreg[P_W-1]};
                    shreg   <= shreg << 1;
                    cnt     <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= COMMIT;
                end
                COMMIT: begin
                    bcd   <= scratch;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures the multiplier product, converts it to BCD and scans the four
// digits onto a common-anode 7-segment display.
module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [5:0]  M,
    input  logic [5:0]  OF,
    input  logic        LOAD,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] BCD,
    output logic [3:0]  AN,
    output logic [6:0]  SEG
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    logic [PRE_W-1:0] pre_cnt;
    logic [1:0]       scan_idx;
    logic [1:0]       idx_next;
    logic             wrap;
    logic [3:0]       nib;
    logic             blank;
    logic [3:1]       lz;

    alu_result_display_bin2bcd_serial u_conv (
        .clk   (CLK),
        .rst_n (RST_N),
        .start (LOAD),
        .din   ({OF, M}),
        .busy  (BUSY),
        .done  (DONE),
        .bcd   (BCD)
    );

    // AN/SEG are computed from the next scan index so both registers move on
    // the same edge as the index itself.
    always_comb begin
        wrap     = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
        idx_next = wrap ? scan_idx + 2'd1 : scan_idx;
        lz[3]    = (BCD[15:12] == 4'd0);
        lz[2]    = lz[3] && (BCD[11:8] == 4'd0);
        lz[1]    = lz[2] && (BCD[7:4] == 4'd0);
        nib      = BCD[3:0];
        blank    = 1'b0;
        case (idx_next)
            2'd0: nib = BCD[3:0];
            2'd1: begin nib = BCD[7:4];   blank = lz[1]; end
            2'd2: begin nib = BCD[11:8];  blank = lz[2]; end
            2'd3: begin nib = BCD[15:12]; blank = lz[3]; end
            default: nib = BCD[3:0];
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_cnt  <= '0;
            scan_idx <= 2'd0;
            AN       <= 4'b1110;
            SEG      <= SEG_0;
        end else begin
            pre_cnt  <= wrap ? '0 : pre_cnt + 1'b1;
            scan_idx <= idx_next;
            AN       <= ~(4'b0001 << idx_next);
            SEG      <= (BLANK_LZ && blank) ? SEG_BLANK : seg_decode(nib);
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a short refresh divider.
module tb_alu_result_display;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic [5:0]  M     = '0;
    logic [5:0]  OF    = '0;
    logic        LOAD  = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic [15:0] BCD;
    logic [3:0]  AN;
    logic [6:0]  SEG;

    int total = 0;
    int bad   = 0;

    alu_result_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .M(M), .OF(OF), .LOAD(LOAD),
        .BUSY(BUSY), .DONE(DONE), .BCD(BCD), .AN(AN), .SEG(SEG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  of_v;
        logic [5:0]  m_v;
        logic [15:0] bcd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // LOAD is high across exactly one rising edge (edge k); returns 1 ns after it.
    task automatic do_load(input logic [5:0] of_v, input logic [5:0] m_v);
        @(negedge CLK);
        OF = of_v; M = m_v; LOAD = 1'b1;
        @(posedge CLK);
        #1 LOAD = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (DONE) cnt++;
        end
    endtask

    // Locks onto the start of the units slot, then checks 4 slots x 4 cycles.
    task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [3:0] prev;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        bit         locked;
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        locked = 1'b0;
        @(negedge CLK);
        prev = AN;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (AN == 4'b1110 && prev == 4'b0111) begin
                locked = 1'b1;
                break;
            end
            prev = AN;
        end
        check("scan_lock", {31'd0, locked}, 32'd1);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("scan_an s%0d c%0d", s, c), {28'd0, AN}, {28'd0, exp_an[s]});
                check($sformatf("scan_seg s%0d c%0d", s, c), {25'd0, SEG}, {25'd0, exp_seg[s]});
                @(negedge CLK);
            end
        end
        check("scan_wrap", {28'd0, AN}, 32'b1110);
    endtask

    vec_t vecs [8];
    int   lat;
    int   nd;

    initial begin
        vecs[0] = '{6'd62, 6'd1,  16'h3969};
        vecs[1] = '{6'd0,  6'd7,  16'h0007};
        vecs[2] = '{6'd0,  6'd0,  16'h0000};
        vecs[3] = '{6'd1,  6'd0,  16'h0064};
        vecs[4] = '{6'd15, 6'd39, 16'h0999};
        vecs[5] = '{6'd16, 6'd40, 16'h1064};
        vecs[6] = '{6'd0,  6'd63, 16'h0063};
        vecs[7] = '{6'd31, 6'd63, 16'h2047};

        repeat (2) @(negedge CLK);
        check("rst_an",   {28'd0, AN},   32'b1110);
        check("rst_seg",  {25'd0, SEG},  32'b1000000);
        check("rst_bcd",  {16'd0, BCD},  32'h0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        foreach (vecs[i]) begin
            do_load(vecs[i].of_v, vecs[i].m_v);
            check($sformatf("v%0d busy_start", i), {31'd0, BUSY}, 32'd1);
            wait_done(lat);
            check($sformatf("v%0d latency", i), lat, 32'd13);
            check($sformatf("v%0d bcd", i), {16'd0, BCD}, {16'd0, vecs[i].bcd});
            check($sformatf("v%0d busy_end", i), {31'd0, BUSY}, 32'd0);
            @(posedge CLK);
            #1;
            check($sformatf("v%0d done_width", i), {31'd0, DONE}, 32'd0);
        end

        // 3969 on the display, then an asynchronous mid-cycle reset
        do_load(6'd62, 6'd1);
        wait_done(lat);
        check("d3969 latency", lat, 32'd13);
        check_scan(7'b0010000, 7'b0000010, 7'b0010000, 7'b0110000);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check("async_an",   {28'd0, AN},   32'b1110);
        check("async_seg",  {25'd0, SEG},  32'b1000000);
        check("async_bcd",  {16'd0, BCD},  32'h0);
        check("async_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Leading-zero blanking
        do_load(6'd0, 6'd7);
        wait_done(lat);
        check("d7 bcd", {16'd0, BCD}, 32'h0007);
        check_scan(7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);

        // LOAD while busy is ignored
        do_load(6'd62, 6'd1);
        repeat (4) @(posedge CLK);
        do_load(6'd0, 6'd3);
        check("ign bcd_hold", {16'd0, BCD}, 32'h0007);
        wait_done(lat);
        check("ign latency", lat, 32'd8);
        check("ign bcd", {16'd0, BCD}, 32'h3969);
        count_dones(20, nd);
        check("ign no_second_done", nd, 32'd0);
        check("ign bcd_after", {16'd0, BCD}, 32'h3969);

        // Reset mid-conversion aborts without DONE
        do_load(6'd62, 6'd1);
        repeat (5) @(posedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("abort bcd",  {16'd0, BCD},  32'h0);
        check("abort busy", {31'd0, BUSY}, 32'd0);
        check("abort done", {31'd0, DONE}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        count_dones(20, nd);
        check("abort no_done", nd, 32'd0);
        do_load(6'd0, 6'd2);
        wait_done(lat);
        check("abort2 latency", lat, 32'd13);
        check("abort2 bcd", {16'd0, BCD}, 32'h0002);

        // Back-to-back: new LOAD presented during the DONE cycle
        do_load(6'd0, 6'd5);
        wait_done(lat);
        check("b2b first bcd", {16'd0, BCD}, 32'h0005);
        OF = 6'd20; M = 6'd17; LOAD = 1'b1;
        @(posedge CLK);
        #1 LOAD = 1'b0;
        check("b2b busy", {31'd0, BUSY}, 32'd1);
        wait_done(lat);
        check("b2b latency", lat, 32'd13);
        check("b2b bcd", {16'd0, BCD}, 32'h1297);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
